// File: rtl/fft_r22sdf_bfii_pkg.sv
// rtl/fft_r22sdf_bfii_pkg.sv - shared constants and helpers for the R2^2 SDF stage blocks
// Purpose: width helpers used by BF-I, BF-II and the twiddle stage.
// Ports: none (package).
package fft_r22sdf_bfii_pkg;

   // Ceiling log2; loop bound is fixed so it elaborates as a constant.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // A stage frame spans 4L samples: 2L through BF-I, then L plus L through BF-II.
   function automatic int stage_frame_len(input int len);
      return 4 * len;
   endfunction

   // Counter width that wraps exactly once per stage frame.
   function automatic int stage_ctr_width(input int len);
      return clog2(len) + 2;
   endfunction

endpackage

// File: rtl/fft_r22sdf_bfii_if.sv
// rtl/fft_r22sdf_bfii_if.sv - sample stream into and out of the BF-II butterfly
// Purpose: groups the input strobe/data and the registered output strobe/data.
// Ports: valid_i, x_re_i, x_im_i (toward the butterfly); valid_o, frame_o,
//        z_re_o, z_im_o (from the butterfly). master = driver, slave = butterfly.
interface fft_r22sdf_bfii_if #(
   parameter int DATA_WIDTH = 25
);
   logic                         valid_i;
   logic signed [DATA_WIDTH-1:0] x_re_i;
   logic signed [DATA_WIDTH-1:0] x_im_i;
   logic                         valid_o;
   logic                         frame_o;
   logic signed [DATA_WIDTH-1:0] z_re_o;
   logic signed [DATA_WIDTH-1:0] z_im_o;

   modport master (
      output valid_i, x_re_i, x_im_i,
      input  valid_o, frame_o, z_re_o, z_im_o
   );

   modport slave (
      input  valid_i, x_re_i, x_im_i,
      output valid_o, frame_o, z_re_o, z_im_o
   );
endinterface

// File: rtl/fft_r22sdf_delay.sv
// rtl/fft_r22sdf_delay.sv - complex shift-register delay line with clock enable
// Purpose: delays a complex sample by LEN enabled clocks; shared by BF-I and BF-II.
// Ports: clk_i, rst_n (sync clear of every entry), ce (shift enable),
//        din_re_i/din_im_i (head), dout_re_o/dout_im_o (tail, LEN shifts old).
module fft_r22sdf_delay #(
   parameter int DATA_WIDTH = 25,
   parameter int LEN        = 256
) (
   input  logic                         clk_i,
   input  logic                         rst_n,
   input  logic                         ce,
   input  logic signed [DATA_WIDTH-1:0] din_re_i,
   input  logic signed [DATA_WIDTH-1:0] din_im_i,
   output logic signed [DATA_WIDTH-1:0] dout_re_o,
   output logic signed [DATA_WIDTH-1:0] dout_im_o
);
   logic signed [DATA_WIDTH-1:0] r_re [LEN];
   logic signed [DATA_WIDTH-1:0] r_im [LEN];

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         for (int i = 0; i < LEN; i++) begin
            r_re[i] <= '0;
            r_im[i] <= '0;
         end
      end else if (ce) begin
         r_re[0] <= din_re_i;
         r_im[0] <= din_im_i;
         for (int i = 1; i < LEN; i++) begin
            r_re[i] <= r_re[i-1];
            r_im[i] <= r_im[i-1];
         end
      end
   end

   assign dout_re_o = r_re[LEN-1];
   assign dout_im_o = r_im[LEN-1];
endmodule

// File: rtl/fft_r22sdf_bfii.sv
// rtl/fft_r22sdf_bfii.sv - BF-II butterfly of one radix-2^2 SDF stage
// Purpose: -j rotation on the last frame quarter, feedback butterfly over L
//          samples, stage frame counter, registered valid-qualified output.
// Ports: clk_i, rst_n (sync active-low); bus (slave): valid_i, x_re_i, x_im_i
//        in; valid_o, frame_o (sample at counter 0), z_re_o, z_im_o out.
module fft_r22sdf_bfii
   import fft_r22sdf_bfii_pkg::*;
#(
   parameter int DATA_WIDTH    = 25,
   parameter int SHIFT_REG_LEN = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_n,
   fft_r22sdf_bfii_if.slave       bus
);
   localparam int CW = stage_ctr_width(SHIFT_REG_LEN);

   logic [CW-1:0]                r_ctr;
   logic                         r_valid;
   logic                         r_frame;
   logic signed [DATA_WIDTH-1:0] r_z_re;
   logic signed [DATA_WIDTH-1:0] r_z_im;

   logic                         w_sel;
   logic                         w_rot;
   logic signed [DATA_WIDTH-1:0] w_xr_re, w_xr_im;
   logic signed [DATA_WIDTH-1:0] w_sr_re, w_sr_im;
   logic signed [DATA_WIDTH-1:0] w_out_re, w_out_im;
   logic signed [DATA_WIDTH-1:0] w_din_re, w_din_im;

   // sel: second half of each 2L group; rot: the last quarter of the 4L frame.
   assign w_sel = r_ctr[CW-2];
   assign w_rot = r_ctr[CW-1] & r_ctr[CW-2];

   always_comb begin
      w_xr_re  = bus.x_re_i;
      w_xr_im  = bus.x_im_i;
      // -j*(a+jb) = b - ja; negation wraps at DATA_WIDTH, so -min stays -min.
      if (w_rot) begin
         w_xr_re = bus.x_im_i;
         w_xr_im = -bus.x_re_i;
      end
      w_out_re = w_sr_re;
      w_out_im = w_sr_im;
      w_din_re = w_xr_re;
      w_din_im = w_xr_im;
      if (w_sel) begin
         w_out_re = w_xr_re + w_sr_re;
         w_out_im = w_xr_im + w_sr_im;
         w_din_re = w_sr_re - w_xr_re;
         w_din_im = w_sr_im - w_xr_im;
      end
   end

   fft_r22sdf_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN        (SHIFT_REG_LEN)
   ) u_delay (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .ce        (bus.valid_i),
      .din_re_i  (w_din_re),
      .din_im_i  (w_din_im),
      .dout_re_o (w_sr_re),
      .dout_im_o (w_sr_im)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_ctr   <= '0;
         r_valid <= 1'b0;
         r_frame <= 1'b0;
         r_z_re  <= '0;
         r_z_im  <= '0;
      end else if (bus.valid_i) begin
         // Counter width makes the 4L-1 -> 0 wrap free.
         r_ctr   <= r_ctr + 1'b1;
         r_valid <= 1'b1;
         r_frame <= (r_ctr == '0);
         r_z_re  <= w_out_re;
         r_z_im  <= w_out_im;
      end else begin
         r_valid <= 1'b0;
         r_frame <= 1'b0;
      end
   end

   assign bus.valid_o = r_valid;
   assign bus.frame_o = r_frame;
   assign bus.z_re_o  = r_z_re;
   assign bus.z_im_o  = r_z_im;
endmodule

// File: tb/tb_fft_r22sdf_bfii.sv
// tb/tb_fft_r22sdf_bfii.sv - directed and long-run checks of the BF-II butterfly
module tb_fft_r22sdf_bfii;
   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk_i = ~clk_i;

   fft_r22sdf_bfii_if #(.DATA_WIDTH(8))  bus1 ();
   fft_r22sdf_bfii_if #(.DATA_WIDTH(16)) bus2 ();
   fft_r22sdf_bfii_if #(.DATA_WIDTH(16)) bus4 ();

   fft_r22sdf_bfii #(.DATA_WIDTH(8),  .SHIFT_REG_LEN(1)) u1 (.clk_i(clk_i), .rst_n(rst_n), .bus(bus1));
   fft_r22sdf_bfii #(.DATA_WIDTH(16), .SHIFT_REG_LEN(2)) u2 (.clk_i(clk_i), .rst_n(rst_n), .bus(bus2));
   fft_r22sdf_bfii #(.DATA_WIDTH(16), .SHIFT_REG_LEN(4)) u4 (.clk_i(clk_i), .rst_n(rst_n), .bus(bus4));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus1.valid_i = 1'b0; bus2.valid_i = 1'b0; bus4.valid_i = 1'b0;
      @(negedge clk_i);
      rst_n = 1'b1;
   endtask

   // One u1 cycle: drive at the negedge, check the registered result one clock later.
   task automatic s1(input string tag, input int re, input int im,
                     input int ere, input int eim, input logic ef);
      bus1.valid_i = 1'b1;
      bus1.x_re_i  = 8'(re);
      bus1.x_im_i  = 8'(im);
      @(negedge clk_i);
      bus1.valid_i = 1'b0;
      chk({tag, "_v"},  bus1.valid_o, 1);
      chk({tag, "_re"}, bus1.z_re_o, ere);
      chk({tag, "_im"}, bus1.z_im_o, eim);
      chk({tag, "_f"},  bus1.frame_o, ef);
   endtask

   task automatic base_frame(input string tag);
      s1({tag, "0"}, 1, 0,  0, 0, 1'b1);
      s1({tag, "1"}, 2, 0,  3, 0, 1'b0);
      s1({tag, "2"}, 3, 0, -1, 0, 1'b0);
      s1({tag, "3"}, 0, 4,  7, 0, 1'b0);
      s1({tag, "4"}, 0, 0, -1, 0, 1'b1);
   endtask

   int e2re [16] = '{0, 0, 4, 6, -2, -2,  5,  6, 5, 6, 4, 6, -2, -2,  5,  6};
   int e2im [16] = '{0, 0, 0, 0,  0,  0, -7, -8, 7, 8, 0, 0,  0,  0, -7, -8};

   logic signed [15:0] md_re [4];
   logic signed [15:0] md_im [4];
   logic signed [15:0] rx, ix, tr, ti, sr_re, sr_im, e_re, e_im, d_re, d_im;
   logic               v, ef, sel, rot;
   int                 mctr, acc, cyc, frames;

   initial begin
      bus1.valid_i = 1'b0; bus1.x_re_i = '0; bus1.x_im_i = '0;
      bus2.valid_i = 1'b0; bus2.x_re_i = '0; bus2.x_im_i = '0;
      bus4.valid_i = 1'b0; bus4.x_re_i = '0; bus4.x_im_i = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_v",  bus1.valid_o, 0);
      chk("rst_f",  bus1.frame_o, 0);
      chk("rst_re", bus1.z_re_o, 0);
      chk("rst_im", bus1.z_im_o, 0);
      rst_n = 1'b1;

      // L=1 basic frame, including the rotated (0,4) -> (4,0) sample.
      base_frame("t1_");

      // -j sign: (5,0) in the rot slot becomes (0,-5).
      do_reset();
      s1("t2_0", 1, 0, 0, 0, 1'b1);
      s1("t2_1", 2, 0, 3, 0, 1'b0);
      s1("t2_2", 3, 0, -1, 0, 1'b0);
      s1("t2_3", 5, 0, 3, -5, 1'b0);
      s1("t2_4", 0, 0, 3, 5, 1'b1);

      // W=8 wrap: rot of (-128,0) gives (0,-128); plus sr=(0,-1) wraps to (0,127).
      do_reset();
      s1("wr_0", 0, 0, 0, 0, 1'b1);
      s1("wr_1", 0, 0, 0, 0, 1'b0);
      s1("wr_2", 0, -1, 0, 0, 1'b0);
      s1("wr_3", -128, 0, 0, 127, 1'b0);

      // Reset mid-frame at ctr=2, with valid_i high in the reset cycle.
      do_reset();
      s1("mr_0", 1, 0, 0, 0, 1'b1);
      s1("mr_1", 2, 0, 3, 0, 1'b0);
      rst_n = 1'b0;
      bus1.valid_i = 1'b1; bus1.x_re_i = 8'sd3; bus1.x_im_i = '0;
      @(negedge clk_i);
      bus1.valid_i = 1'b0;
      rst_n = 1'b1;
      chk("mr_v",  bus1.valid_o, 0);
      chk("mr_f",  bus1.frame_o, 0);
      chk("mr_re", bus1.z_re_o, 0);
      chk("mr_im", bus1.z_im_o, 0);
      base_frame("mr_f");

      // L=2, two frames of (1..8,0) with a one-cycle gap after every sample.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus2.valid_i = 1'b1;
         bus2.x_re_i  = 16'((i % 8) + 1);
         bus2.x_im_i  = '0;
         @(negedge clk_i);
         bus2.valid_i = 1'b0;
         chk($sformatf("l2_v%0d", i),  bus2.valid_o, 1);
         chk($sformatf("l2_re%0d", i), bus2.z_re_o, e2re[i]);
         chk($sformatf("l2_im%0d", i), bus2.z_im_o, e2im[i]);
         chk($sformatf("l2_f%0d", i),  bus2.frame_o, (i % 8 == 0) ? 1 : 0);
         bus2.x_re_i = 16'sd99;
         @(negedge clk_i);
         chk($sformatf("l2_gv%0d", i),  bus2.valid_o, 0);
         chk($sformatf("l2_gf%0d", i),  bus2.frame_o, 0);
         chk($sformatf("l2_gre%0d", i), bus2.z_re_o, e2re[i]);
         chk($sformatf("l2_gim%0d", i), bus2.z_im_o, e2im[i]);
      end

      // L=4 random run over 100 frames with random gaps, against a reference model.
      do_reset();
      for (int i = 0; i < 4; i++) begin md_re[i] = '0; md_im[i] = '0; end
      mctr = 0; acc = 0; cyc = 0; frames = 0; e_re = '0; e_im = '0; ef = 1'b0;
      while (acc < 1600 && cyc < 10000) begin
         cyc++;
         v  = ($urandom_range(0, 3) != 0);
         rx = 16'($urandom);
         ix = 16'($urandom);
         bus4.valid_i = v; bus4.x_re_i = rx; bus4.x_im_i = ix;
         if (v) begin
            sel = ((mctr % 8) >= 4);
            rot = (mctr >= 12);
            if (rot) begin tr = ix; ti = -rx; end
            else     begin tr = rx; ti = ix;  end
            sr_re = md_re[3]; sr_im = md_im[3];
            if (sel) begin
               e_re = tr + sr_re; e_im = ti + sr_im;
               d_re = sr_re - tr; d_im = sr_im - ti;
            end else begin
               e_re = sr_re; e_im = sr_im;
               d_re = tr;    d_im = ti;
            end
            for (int k = 3; k > 0; k--) begin md_re[k] = md_re[k-1]; md_im[k] = md_im[k-1]; end
            md_re[0] = d_re; md_im[0] = d_im;
            ef = (mctr == 0);
            mctr = (mctr + 1) % 16;
            acc++;
         end
         @(negedge clk_i);
         bus4.valid_i = 1'b0;
         chk($sformatf("rn_v%0d", cyc),  bus4.valid_o, v);
         chk($sformatf("rn_f%0d", cyc),  bus4.frame_o, v & ef);
         chk($sformatf("rn_re%0d", cyc), bus4.z_re_o, e_re);
         chk($sformatf("rn_im%0d", cyc), bus4.z_im_o, e_im);
         if (bus4.frame_o === 1'b1) frames++;
      end
      chk("rn_accepted", acc, 1600);
      chk("rn_frames", frames, 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
